// File: rtl/vin_frequency_hz.sv
// rtl/vin_frequency_hz.sv - period-to-frequency converter using a 32-step restoring divider
module vin_frequency_hz #(
    parameter logic [31:0] CLK_FREQ = 32'd16000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] period,
    output logic [31:0] frequency,
    output logic        update,
    output logic        stopped
);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t      state;
    logic [31:0] p_lat;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [4:0]  cnt;

    logic [32:0] trial;
    logic        fits;
    logic [31:0] diff;

    // The true difference is below p_lat, so 32-bit wraparound subtraction is exact.
    assign trial = {rem, quo[31]};
    assign fits  = trial >= {1'b0, p_lat};
    assign diff  = trial[31:0] - p_lat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            p_lat     <= '0;
            quo       <= '0;
            rem       <= '0;
            cnt       <= '0;
            frequency <= '0;
            update    <= 1'b0;
            stopped   <= 1'b0;
        end else begin
            update <= 1'b0;
            case (state)
                IDLE: begin
                    p_lat <= period;
                    quo   <= CLK_FREQ;
                    rem   <= '0;
                    cnt   <= 5'd31;
                    state <= DIV;
                end
                DIV: begin
                    if (fits) begin
                        rem <= diff;
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= trial[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Divide-by-zero quotient is never published.
                    if (p_lat == 32'd0) begin
                        frequency <= '0;
                        stopped   <= 1'b1;
                    end else begin
                        frequency <= quo;
                        stopped   <= 1'b0;
                    end
                    update <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
